// File: rtl/seq_det_event_logger_pkg.sv
// Shared definitions for the sequence-detector event logger.
//   logger_state_t : logger FSM states (IDLE, RUN, OVF)
//   DEF_*          : default widths/depth used by the logger and its interface
//   DET_PATTERN    : bit pattern recognised by the upstream Mealy detector
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVF  = 2'd2
    } logger_state_t;

    localparam int DEF_TS_W  = 16;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_CNT_W = 16;

    // Detector-domain constants, kept here so detector and logger agree.
    localparam logic [2:0] DET_PATTERN     = 3'b101;
    localparam int         DET_PATTERN_LEN = 3;

endpackage

// File: rtl/seq_det_event_logger_if.sv
// Valid/ready drain port carrying event timestamps out of the logger.
//   evt_valid : head entry present
//   evt_ready : consumer accepts head when evt_valid & evt_ready
//   evt_ts    : head timestamp (0 while evt_valid = 0)
// master = logger side, slave = consumer side.
interface seq_det_event_logger_if
    import seq_det_pkg::*;
#(
    parameter int TS_W = DEF_TS_W
);
    logic            evt_valid;
    logic            evt_ready;
    logic [TS_W-1:0] evt_ts;

    modport master (output evt_valid, output evt_ts, input evt_ready);
    modport slave  (input evt_valid, input evt_ts, output evt_ready);
endinterface

// File: rtl/seq_det_event_logger_sync_fifo.sv
// Small synchronous FIFO with show-ahead read data.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous flush (overrides push and pop)
//   push     : write request; accepted when not full, or when full and a pop
//              happens in the same cycle
//   pop      : read request; ignored while empty
//   wdata    : write data
//   rdata    : head entry, 0 while empty
//   full, empty, level : occupancy status (level is 0..DEPTH)
module sync_fifo
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign empty = (level_q == '0);
    assign full  = (level_q == FULL_LVL);
    assign level = level_q;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    // A pop frees the slot the push needs, so full-with-pop still accepts.
    assign do_pop  = pop & ~empty & ~clr;
    assign do_push = push & ~clr & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; empty masks stale contents on rdata.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/seq_det_event_logger.sv
// Timestamps every detector pulse and buffers the stamps for a consumer.
//   clk, rst   : clock, asynchronous active-high reset
//   det_in     : detector output, one event per edge sampled high
//   en         : gates timestamp counter and event capture
//   clr        : synchronous clear of FIFO, counters and FSM
//   evt        : valid/ready drain port (master side)
//   total_cnt  : saturating count of captured events (stored or dropped)
//   drop_cnt   : saturating count of events that could not be stored
//   fifo_level : current FIFO occupancy
//   overflow   : high while the logger sits in OVF
module seq_det_event_logger
    import seq_det_pkg::*;
#(
    parameter int TS_W         = DEF_TS_W,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int STOP_ON_FULL = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       det_in,
    input  logic                       en,
    input  logic                       clr,
    seq_det_event_logger_if.master     evt,
    output logic [CNT_W-1:0]           total_cnt,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow
);
    logger_state_t    state_q, state_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             capture, stop_block, pop_fire, push_req, push_ok, drop;
    logic             fifo_full, fifo_empty;
    logic [TS_W-1:0]  fifo_rdata;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    sync_fifo #(
        .WIDTH (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (push_req),
        .pop   (evt.evt_ready),
        .wdata (ts_q),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign capture    = en & det_in & ~clr;
    assign stop_block = (STOP_ON_FULL != 0) && (state_q == OVF);
    assign pop_fire   = ~fifo_empty & evt.evt_ready & ~clr;
    assign push_req   = capture & ~stop_block;
    // Mirrors the FIFO's own acceptance rule so drops are counted exactly.
    assign push_ok    = push_req & (~fifo_full | pop_fire);
    assign drop       = capture & ~push_ok;

    always_comb begin
        state_d = state_q;
        ts_d    = ts_q;
        total_d = total_q;
        drop_d  = drop_q;
        if (clr) begin
            state_d = IDLE;
            ts_d    = '0;
            total_d = '0;
            drop_d  = '0;
        end else begin
            if (en)      ts_d    = ts_q + 1'b1;
            if (capture) total_d = sat_inc(total_q);
            if (drop)    drop_d  = sat_inc(drop_q);
            case (state_q)
                IDLE:    if (drop) state_d = OVF; else if (en)  state_d = RUN;
                RUN:     if (drop) state_d = OVF; else if (!en) state_d = IDLE;
                OVF:     state_d = OVF; // only clr leaves OVF
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ts_q    <= '0;
            total_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_d;
            total_q <= total_d;
            drop_q  <= drop_d;
        end
    end

    assign evt.evt_valid = ~fifo_empty;
    assign evt.evt_ts    = fifo_rdata;
    assign total_cnt     = total_q;
    assign drop_cnt      = drop_q;
    assign overflow      = (state_q == OVF);

endmodule

// File: tb/tb_seq_det_event_logger.sv
// Directed bench: two loggers (STOP_ON_FULL=0 with 16-bit counters, and
// STOP_ON_FULL=1 with 3-bit counters to reach saturation) share stimulus.
// Expected timestamps are queued when an event is driven and compared as
// the head of each FIFO is presented.
module tb_seq_det_event_logger;
    import seq_det_pkg::*;

    logic clk = 1'b0;
    logic rst, det_in, en, clr, rdy;

    seq_det_event_logger_if #(.TS_W(4)) if_a ();
    seq_det_event_logger_if #(.TS_W(4)) if_b ();
    assign if_a.evt_ready = rdy;
    assign if_b.evt_ready = rdy;

    logic [15:0] tot_a, drop_a;
    logic [2:0]  tot_b, drop_b;
    logic [3:0]  lvl_a, lvl_b;
    logic        ovf_a, ovf_b;

    seq_det_event_logger #(.TS_W(4), .DEPTH(8), .CNT_W(16), .STOP_ON_FULL(0)) dut_a (
        .clk(clk), .rst(rst), .det_in(det_in), .en(en), .clr(clr), .evt(if_a.master),
        .total_cnt(tot_a), .drop_cnt(drop_a), .fifo_level(lvl_a), .overflow(ovf_a));

    seq_det_event_logger #(.TS_W(4), .DEPTH(8), .CNT_W(3), .STOP_ON_FULL(1)) dut_b (
        .clk(clk), .rst(rst), .det_in(det_in), .en(en), .clr(clr), .evt(if_b.master),
        .total_cnt(tot_b), .drop_cnt(drop_b), .fifo_level(lvl_b), .overflow(ovf_b));

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference state.
    logic [3:0] sb_a[$];
    logic [3:0] sb_b[$];
    int         m_ts;
    int         m_tot [2];
    int         m_drop[2];
    bit         m_ovf [2];
    int         stop_k[2] = '{0, 1};
    int         cmax_k[2] = '{65535, 7};

    function automatic int sb_size(input int k);
        return (k == 0) ? sb_a.size() : sb_b.size();
    endfunction

    function automatic int sb_head(input int k);
        if (sb_size(k) == 0) return 0;
        return (k == 0) ? int'(sb_a[0]) : int'(sb_b[0]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb_a.delete();
        sb_b.delete();
        m_ts = 0;
        for (int k = 0; k < 2; k++) begin
            m_tot[k] = 0; m_drop[k] = 0; m_ovf[k] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic d, input logic e, input logic c, input logic r);
        for (int k = 0; k < 2; k++) begin
            bit cap, popf, pushok;
            cap    = e && d && !c;
            popf   = (sb_size(k) > 0) && r && !c;
            pushok = cap && !(stop_k[k] != 0 && m_ovf[k]) && ((sb_size(k) < 8) || popf);
            if (c) begin
                if (k == 0) sb_a.delete(); else sb_b.delete();
                m_tot[k] = 0; m_drop[k] = 0; m_ovf[k] = 1'b0;
            end else begin
                if (popf)   begin if (k == 0) void'(sb_a.pop_front()); else void'(sb_b.pop_front()); end
                if (pushok) begin if (k == 0) sb_a.push_back(m_ts[3:0]); else sb_b.push_back(m_ts[3:0]); end
                if (cap && m_tot[k] < cmax_k[k]) m_tot[k]++;
                if (cap && !pushok) begin
                    if (m_drop[k] < cmax_k[k]) m_drop[k]++;
                    m_ovf[k] = 1'b1;
                end
            end
        end
        if (c)      m_ts = 0;
        else if (e) m_ts = (m_ts + 1) % 16;
    endtask

    task automatic check_all();
        chk("valid_a", 32'(if_a.evt_valid), 32'(sb_size(0) > 0));
        chk("ts_a",    32'(if_a.evt_ts),    32'(sb_head(0)));
        chk("level_a", 32'(lvl_a),          32'(sb_size(0)));
        chk("total_a", 32'(tot_a),          32'(m_tot[0]));
        chk("drop_a",  32'(drop_a),         32'(m_drop[0]));
        chk("ovf_a",   32'(ovf_a),          32'(m_ovf[0]));
        chk("valid_b", 32'(if_b.evt_valid), 32'(sb_size(1) > 0));
        chk("ts_b",    32'(if_b.evt_ts),    32'(sb_head(1)));
        chk("level_b", 32'(lvl_b),          32'(sb_size(1)));
        chk("total_b", 32'(tot_b),          32'(m_tot[1]));
        chk("drop_b",  32'(drop_b),         32'(m_drop[1]));
        chk("ovf_b",   32'(ovf_b),          32'(m_ovf[1]));
    endtask

    // Inputs are applied between edges; outputs are checked 1 ns after the edge.
    task automatic step(input logic d, input logic e, input logic c, input logic r);
        det_in = d; en = e; clr = c; rdy = r;
        @(posedge clk);
        model_edge(d, e, c, r);
        #1;
        check_all();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; det_in = 1'b0; en = 1'b0; clr = 1'b0; rdy = 1'b0;
        model_reset();
        #12;
        check_all();
        rst = 1'b0;

        // Basic timestamps: events at ts 3 and 5.
        step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
        step(1, 1, 0, 0); step(0, 1, 0, 0); step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("basic_level", 32'(lvl_a), 32'd2);
        chk("basic_total", 32'(tot_a), 32'd2);
        chk("basic_head",  32'(if_a.evt_ts), 32'd3);
        step(0, 0, 0, 1);
        chk("basic_second", 32'(if_a.evt_ts), 32'd5);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);          // pop on empty: no effect

        // Fill and overflow: ten consecutive events from ts 0.
        step(0, 0, 1, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
        chk("ovf_level", 32'(lvl_a),  32'd8);
        chk("ovf_total", 32'(tot_a),  32'd10);
        chk("ovf_drop",  32'(drop_a), 32'd2);
        chk("ovf_flag",  32'(ovf_a),  32'd1);
        chk("sat_total_b", 32'(tot_b), 32'd7);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1);

        // Full FIFO with simultaneous push and pop, then overflow.
        step(0, 0, 1, 0);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
        step(1, 1, 0, 1);
        chk("pp_level", 32'(lvl_a),  32'd8);
        chk("pp_drop",  32'(drop_a), 32'd0);
        step(1, 1, 0, 0);
        // Drain three, then two more events.
        step(0, 1, 0, 1); step(0, 1, 0, 1); step(0, 1, 0, 1);
        step(1, 1, 0, 0); step(1, 1, 0, 0);
        chk("stop_level_b", 32'(lvl_b),  32'd5);
        chk("stop_drop_b",  32'(drop_b), 32'd3);
        chk("stop_ovf_b",   32'(ovf_b),  32'd1);
        chk("run_level_a",  32'(lvl_a),  32'd7);
        step(0, 0, 1, 0);
        chk("clr_ovf_b", 32'(ovf_b), 32'd0);

        // en gating and timestamp wrap.
        step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
        for (int i = 0; i < 15; i++) step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("wrap_head", 32'(if_a.evt_ts), 32'd15);
        step(1, 1, 0, 0);
        chk("pre_rst_level", 32'(lvl_a), 32'd3);

        // Asynchronous reset between edges.
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        rst = 1'b0;
        step(1, 1, 0, 0);
        step(0, 1, 0, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
